led_matrix_scan_sched: RTL and testbench
========================================

// Module: led_matrix_scan_sched
// PURPOSE
//  Column-scan scheduler for the 8x8 common-anode RGB matrix (DATA_R/G/B active-low, rgb_com={en,col}).
//  Game logic writes whole columns into a back frame buffer; the block scans the front buffer column by
//  column, blanks outputs between columns to suppress ghosting, and swaps buffers only at frame boundaries.
//  Sits between game/FSM logic and the matrix pins; it replaces ad-hoc per-object multiplexing in game logic.
// PARAMETERS
//  DWELL_CYCLES  50000  CLK cycles a column is driven (>=2)
//  BLANK_CYCLES  500    CLK cycles outputs are blanked before each column (>=1)
// PORTS
//  CLK        in   1  system clock
//  RST        in   1  asynchronous reset, active-high
//  wr_en      in   1  write column into back buffer (accepted only when wr_ready=1)
//  wr_col     in   3  column index 0..7
//  wr_r       in   8  red pixels of column, active-high (1 = lit), bit n = row n
//  wr_g       in   8  green pixels, active-high
//  wr_b       in   8  blue pixels, active-high
//  wr_ready   out  1  1 = back buffer writable (no swap pending)
//  swap_req   in   1  request back->front swap at next frame boundary
//  swap_done  out  1  1-cycle pulse on the cycle the swap takes effect
//  frame_start out 1  1-cycle pulse on the first DRIVE cycle of column 0
//  DATA_R     out  8  red row drive, active-low
//  DATA_G     out  8  green row drive, active-low
//  DATA_B     out  8  blue row drive, active-low
//  rgb_com    out  4  {enable, column[2:0]}
// BEHAVIOUR
//  - Reset: both buffers all-off, front=buf0, col=0, state=BLANK, counter=0, swap_pending=0;
//    DATA_R/G/B=8'hFF, rgb_com=4'b0000, wr_ready=1, swap_done=0, frame_start=0. All outputs registered.
//  - FSM BLANK: DATA_*=8'hFF, rgb_com=4'b0000; after BLANK_CYCLES cycles -> DRIVE (same col).
//  - FSM DRIVE: DATA_x = ~front[col].x, rgb_com={1'b1,col}; after DWELL_CYCLES cycles -> BLANK, col=col+1
//    (3-bit wrap 7->0). Frame period = 8*(BLANK_CYCLES+DWELL_CYCLES) cycles.
//  - Counter reloads to 0 on every state change; compare against PARAM-1; width $clog2(max(D,B)+1).
//  - Write: on wr_en & wr_ready, back[wr_col] <= {wr_r,wr_g,wr_b} at the clock edge; wr_en with
//    wr_ready=0 is dropped (no buffering). Front buffer is never written directly.
//  - swap_req with swap_pending=0: swap_pending<=1, wr_ready<=0 next cycle. swap_req while pending: ignored.
//    A write and swap_req in the same cycle: write is accepted, then pending set.
//  - Frame boundary = last DRIVE cycle of col 7. If swap_pending was set before that cycle: front/back
//    select toggles, swap_pending<=0, wr_ready<=1, swap_done pulses next cycle. swap_req arriving on the
//    boundary cycle itself is registered and swaps at the following boundary.
//  - New front data first appears on the frame_start cycle; a frame is never displayed half-old/half-new.
//  - After swap, back buffer holds the previous front frame (no clear); logic rewrites what changes.
//  - RST mid-frame: immediate return to reset values; pending swap discarded; buffer contents cleared.
// CONFIGURATION
//  LEDM_SCAN_DIM_EN defined: extra input dim_lvl[2:0]; within DRIVE, DATA_* show the pixels only while
//    counter < ((dim_lvl+1)*DWELL_CYCLES)>>3, else 8'hFF with rgb_com unchanged; dim_lvl sampled at
//    frame_start, so it applies from the next full frame; dim_lvl=7 = full brightness.
//  Not defined: no dim_lvl port; pixels driven for full DWELL_CYCLES.
// TESTING (DWELL_CYCLES=8, BLANK_CYCLES=2)
//  1 Reset release, no writes -> DATA_*=FF always; rgb_com 0000 x2, 1000 x8, 0000 x2, 1001 x8...; frame_start every 80 cycles.
//  2 Write col3 r=8'h81, swap_req; at next boundary -> swap_done pulse; col3 DRIVE shows DATA_R=8'h7E, G/B=FF.
//  3 swap_req then wr_en col0 before boundary -> write dropped; after swap, col0 still all-off.
//  4 swap_req asserted on col7 last DRIVE cycle -> no swap this boundary; swap_done 80 cycles later.
//  5 RST pulsed mid col5 DRIVE with swap pending -> outputs FF/0000 immediately, wr_ready=1, no swap_done.
//  6 LEDM_SCAN_DIM_EN, dim_lvl=1 -> per column pixels driven 2 of 8 DRIVE cycles, FF the other 6.

Source files
------------

// File: rtl/led_matrix_scan_sched.sv
// Column-scan scheduler for an 8x8 common-anode RGB matrix with double-buffered frames.
// Optional macro LEDM_SCAN_DIM_EN adds a per-frame dim_lvl[2:0] brightness input.
module led_matrix_scan_sched #(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [2:0] wr_col,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_g,
    input  logic [7:0] wr_b,
    output logic       wr_ready,
    input  logic       swap_req,
`ifdef LEDM_SCAN_DIM_EN
    input  logic [2:0] dim_lvl,
`endif
    output logic       swap_done,
    output logic       frame_start,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B,
    output logic [3:0] rgb_com
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_col_t;

    // Two column buffers; front_sel picks the one being scanned, the other takes writes.
    pix_col_t [1:0][7:0] mem;
    logic                front_sel;
    logic                pending;

    state_t           state,    nx_state;
    logic [2:0]       col,      nx_col;
    logic [CNT_W-1:0] cnt,      nx_cnt;

    logic       boundary;
    logic       do_swap;
    logic       nx_pending;
    logic       nx_front;
    logic       nx_fs;
    logic       nx_drive;
    logic       lit;
    pix_col_t   pix;
    logic [7:0] nx_r;
    logic [7:0] nx_g;
    logic [7:0] nx_b;
    logic [3:0] nx_com;

`ifdef LEDM_SCAN_DIM_EN
    logic [2:0] dim_q;
    logic [2:0] nx_dim;
`endif

    // Next-state and next-output computation; outputs are registered from these values.
    always_comb begin
        nx_state = state;
        nx_col   = col;
        nx_cnt   = cnt + CNT_W'(1);
        if (state == ST_BLANK) begin
            if (cnt == BLANK_LAST) begin
                nx_state = ST_DRIVE;
                nx_cnt   = '0;
            end
        end else begin
            if (cnt == DWELL_LAST) begin
                nx_state = ST_BLANK;
                nx_col   = col + 3'd1;
                nx_cnt   = '0;
            end
        end

        boundary   = (state == ST_DRIVE) && (col == 3'd7) && (cnt == DWELL_LAST);
        do_swap    = boundary && pending;
        nx_pending = do_swap ? 1'b0 : (pending | swap_req);
        nx_front   = front_sel ^ do_swap;
        nx_fs      = (state == ST_BLANK) && (nx_state == ST_DRIVE) && (nx_col == 3'd0);
        nx_drive   = (nx_state == ST_DRIVE);
        pix        = mem[nx_front][nx_col];

`ifdef LEDM_SCAN_DIM_EN
        // Brightness is latched as a frame begins so one frame never mixes levels.
        nx_dim = nx_fs ? dim_lvl : dim_q;
        lit    = 32'(nx_cnt) < (((32'(nx_dim) + 32'd1) * DWELL_CYCLES) >> 3);
`else
        lit    = 1'b1;
`endif

        nx_r   = (nx_drive && lit) ? ~pix.r : 8'hFF;
        nx_g   = (nx_drive && lit) ? ~pix.g : 8'hFF;
        nx_b   = (nx_drive && lit) ? ~pix.b : 8'hFF;
        nx_com = nx_drive ? {1'b1, nx_col} : 4'b0000;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_BLANK;
            col         <= 3'd0;
            cnt         <= '0;
            mem         <= '0;
            front_sel   <= 1'b0;
            pending     <= 1'b0;
            wr_ready    <= 1'b1;
            swap_done   <= 1'b0;
            frame_start <= 1'b0;
            DATA_R      <= 8'hFF;
            DATA_G      <= 8'hFF;
            DATA_B      <= 8'hFF;
            rgb_com     <= 4'b0000;
`ifdef LEDM_SCAN_DIM_EN
            dim_q       <= 3'd7;
`endif
        end else begin
            state       <= nx_state;
            col         <= nx_col;
            cnt         <= nx_cnt;
            front_sel   <= nx_front;
            pending     <= nx_pending;
            wr_ready    <= ~nx_pending;
            swap_done   <= do_swap;
            frame_start <= nx_fs;
            DATA_R      <= nx_r;
            DATA_G      <= nx_g;
            DATA_B      <= nx_b;
            rgb_com     <= nx_com;
`ifdef LEDM_SCAN_DIM_EN
            dim_q       <= nx_dim;
`endif
            // Writes land in the back buffer only while no swap is pending.
            if (wr_en && wr_ready) begin
                mem[~front_sel][wr_col] <= {wr_r, wr_g, wr_b};
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_sched.sv
// Bench for led_matrix_scan_sched: directed scenarios plus random traffic against a frame-level model.
module tb_led_matrix_scan_sched;

    localparam int D = 8;
    localparam int B = 2;
    localparam int P = D + B;
    localparam int F = 8 * P;

    logic       CLK = 1'b0;
    logic       RST;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [7:0] wr_r, wr_g, wr_b;
    logic       wr_ready;
    logic       swap_req;
    logic [2:0] dim_lvl;
    logic       swap_done;
    logic       frame_start;
    logic [7:0] DATA_R, DATA_G, DATA_B;
    logic [3:0] rgb_com;

    led_matrix_scan_sched #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .CLK(CLK),
        .RST(RST),
        .wr_en(wr_en),
        .wr_col(wr_col),
        .wr_r(wr_r),
        .wr_g(wr_g),
        .wr_b(wr_b),
        .wr_ready(wr_ready),
        .swap_req(swap_req),
`ifdef LEDM_SCAN_DIM_EN
        .dim_lvl(dim_lvl),
`endif
        .swap_done(swap_done),
        .frame_start(frame_start),
        .DATA_R(DATA_R),
        .DATA_G(DATA_G),
        .DATA_B(DATA_B),
        .rgb_com(rgb_com)
    );

    always #5 CLK = ~CLK;

    // Reference model: displayed/back frames, swap flag, and cycle index since reset release.
    logic [23:0] front [8];
    logic [23:0] back  [8];
    bit          pending;
    bit          sd;
    int          t;
    int          dim_act;
    int          ncmp = 0;
    int          nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            front[i] = '0;
            back[i]  = '0;
        end
        pending = 0;
        sd      = 0;
        t       = 0;
        dim_act = 7;
    endtask

    task automatic check_outputs();
        int pos, c, off;
        bit drv, lit;
        logic [23:0] px;
        logic [7:0] er, eg, eb;
        pos = t % F;
        c   = pos / P;
        off = pos % P;
        drv = (off >= B);
        lit = drv;
`ifdef LEDM_SCAN_DIM_EN
        lit = drv && ((off - B) < (((dim_act + 1) * D) >> 3));
`endif
        px = front[c];
        er = lit ? ~px[23:16] : 8'hFF;
        eg = lit ? ~px[15:8]  : 8'hFF;
        eb = lit ? ~px[7:0]   : 8'hFF;
        chk("rgb_com", 32'(rgb_com), drv ? 32'(8 + c) : 32'd0);
        chk("DATA_R", 32'(DATA_R), 32'(er));
        chk("DATA_G", 32'(DATA_G), 32'(eg));
        chk("DATA_B", 32'(DATA_B), 32'(eb));
        chk("frame_start", 32'(frame_start), 32'(pos == B));
        chk("swap_done", 32'(swap_done), 32'(sd));
        chk("wr_ready", 32'(wr_ready), 32'(!pending));
    endtask

    task automatic model_update();
        logic [23:0] tmp;
        bit boundary;
        boundary = ((t % F) == F - 1);
        if (wr_en && !pending) back[wr_col] = {wr_r, wr_g, wr_b};
`ifdef LEDM_SCAN_DIM_EN
        if ((t % F) == B - 1) dim_act = int'(dim_lvl);
`endif
        sd = 0;
        if (boundary && pending) begin
            for (int i = 0; i < 8; i++) begin
                tmp      = front[i];
                front[i] = back[i];
                back[i]  = tmp;
            end
            pending = 0;
            sd      = 1;
        end else if (swap_req) begin
            pending = 1;
        end
        t++;
    endtask

    task automatic cyc(input logic we, input logic [2:0] c, input logic [23:0] d, input logic sr);
        wr_en    = we;
        wr_col   = c;
        {wr_r, wr_g, wr_b} = d;
        swap_req = sr;
        @(negedge CLK);
        check_outputs();
        model_update();
        @(posedge CLK);
        #1;
        wr_en    = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_DATA_R"}, 32'(DATA_R), 32'hFF);
        chk({tag, "_DATA_G"}, 32'(DATA_G), 32'hFF);
        chk({tag, "_DATA_B"}, 32'(DATA_B), 32'hFF);
        chk({tag, "_rgb_com"}, 32'(rgb_com), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_swap_done"}, 32'(swap_done), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        RST      = 1'b1;
        wr_en    = 1'b0;
        wr_col   = 3'd0;
        wr_r     = 8'h00;
        wr_g     = 8'h00;
        wr_b     = 8'h00;
        swap_req = 1'b0;
        dim_lvl  = 3'd7;
        model_reset();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();

        // Idle scan: blank/drive cadence and frame_start period.
        repeat (170) cyc(1'b0, 3'd0, 24'h0, 1'b0);

        // Write col3 red 0x81 together with a swap request.
        cyc(1'b1, 3'd3, {8'h81, 8'h00, 8'h00}, 1'b1);
        repeat (200) cyc(1'b0, 3'd0, 24'h0, 1'b0);

        // Write attempted after swap_req must be dropped.
        cyc(1'b0, 3'd0, 24'h0, 1'b1);
        cyc(1'b1, 3'd0, 24'hFFFFFF, 1'b0);
        repeat (180) cyc(1'b0, 3'd0, 24'h0, 1'b0);

        // swap_req on the boundary cycle itself defers to the following boundary.
        for (int k = 0; k < F && (t % F) != F - 1; k++) cyc(1'b0, 3'd0, 24'h0, 1'b0);
        cyc(1'b0, 3'd0, 24'h0, 1'b1);
        repeat (170) cyc(1'b0, 3'd0, 24'h0, 1'b0);

        // Reset in the middle of col5 DRIVE with a swap pending.
        cyc(1'b1, 3'd5, 24'h5A3C0F, 1'b1);
        for (int k = 0; k < F && (t % F) != 5 * P + B + 3; k++) cyc(1'b0, 3'd0, 24'h0, 1'b0);
        RST = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        repeat (100) cyc(1'b0, 3'd0, 24'h0, 1'b0);

`ifdef LEDM_SCAN_DIM_EN
        // Fill front with lit pixels, then dim to level 1.
        for (int c = 0; c < 8; c++) cyc(1'b1, 3'(c), 24'hFFFFFF, 1'b0);
        cyc(1'b0, 3'd0, 24'h0, 1'b1);
        dim_lvl = 3'd1;
        repeat (250) cyc(1'b0, 3'd0, 24'h0, 1'b0);
        dim_lvl = 3'd7;
`endif

        // Random traffic: writes, occasional swap requests.
        for (int k = 0; k < 700; k++) begin
`ifdef LEDM_SCAN_DIM_EN
            if ($urandom_range(0, 99) == 0) dim_lvl = 3'($urandom_range(0, 7));
`endif
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 24'($urandom),
                1'($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
